// File: rtl/debounce_pkg.sv
// debounce_pkg: shared widths and default limits for the debounce bank.
package debounce_pkg;
  localparam int DEBOUNCE_10MS_25MHZ = 250_000;
  localparam int HOLD_1S_25MHZ = 25_000_000;
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch channel with synchroniser, stability counter,
// edge pulses and long-press detection.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int HOLD_LIMIT = HOLD_1S_25MHZ,
  parameter logic INVERT = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Held,
  output logic o_Held_Pulse
);
  localparam int DW = cnt_width(DEBOUNCE_LIMIT);
  localparam int HW = cnt_width(HOLD_LIMIT);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_LIMIT);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_LIMIT);
  logic [1:0] r_sync;
  logic r_state, r_out, r_rise, r_fall, r_held, r_held_pulse;
  logic [DW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic w_diff, w_at_max, w_held_nxt;
  logic [HW-1:0] w_hold_nxt;
  assign w_diff = r_sync[1] ^ r_state;
  assign w_at_max = r_cnt == D_MAX;
  assign w_hold_nxt = !r_out ? '0 : (r_hold == H_MAX) ? r_hold : r_hold + 1'b1;
  assign w_held_nxt = w_hold_nxt == H_MAX;
  // At the limit the counter always restarts; only a still-differing sample commits.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync <= '0;
      r_state <= 1'b0;
      r_cnt <= '0;
      r_out <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_hold <= '0;
      r_held <= 1'b0;
      r_held_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_Switch ^ INVERT};
      r_cnt <= (w_diff && !w_at_max) ? r_cnt + 1'b1 : '0;
      r_state <= r_state ^ (w_diff && w_at_max);
      r_out <= r_state;
      r_rise <= r_state & ~r_out;
      r_fall <= ~r_state & r_out;
      r_hold <= w_hold_nxt;
      r_held <= w_held_nxt;
      r_held_pulse <= w_held_nxt & ~r_held;
    end
  end
  assign o_Switch = r_out;
  assign o_Rise = r_rise;
  assign o_Fall = r_fall;
  assign o_Held = r_held;
  assign o_Held_Pulse = r_held_pulse;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CH independent debounce channels with optional
// per-channel inversion so a pressed button always reads as 1.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ,
  parameter int HOLD_LIMIT = HOLD_1S_25MHZ,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Held,
  output logic [NUM_CH-1:0] o_Held_Pulse
);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .HOLD_LIMIT(HOLD_LIMIT),
      .INVERT(ACTIVE_LOW[n])
    ) u_ch (
      .i_Clk(i_Clk),
      .i_Reset(i_Reset),
      .i_Switch(i_Switch[n]),
      .o_Switch(o_Switch[n]),
      .o_Rise(o_Rise[n]),
      .o_Fall(o_Fall[n]),
      .o_Held(o_Held[n]),
      .o_Held_Pulse(o_Held_Pulse[n])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus random stimulus against a
// sample-history reference model of the debounce bank.
module tb_debounce_bank;
  localparam int DL = 4;
  localparam int HL = 10;
  localparam logic [1:0] AL = 2'b10;
  logic clk;
  logic i_Reset;
  logic [1:0] i_Switch, o_Switch, o_Rise, o_Fall, o_Held, o_Held_Pulse;
  int n_tests, n_fail, cyc;
  int rise_cnt[2], fall_cnt[2];
  bit xq[2][$];
  bit sh[2][$];
  bit st[2];
  int age[2];
  logic [1:0] m_out, m_rise, m_fall, m_held, m_hp;

  debounce_bank #(
    .NUM_CH(2),
    .DEBOUNCE_LIMIT(DL),
    .HOLD_LIMIT(HL),
    .ACTIVE_LOW(AL)
  ) dut (
    .i_Clk(clk),
    .i_Reset(i_Reset),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise(o_Rise),
    .o_Fall(o_Fall),
    .o_Held(o_Held),
    .o_Held_Pulse(o_Held_Pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // A level is accepted once DL+1 consecutive synchronised samples disagree
  // with it; the output shows it one edge later.
  function automatic void model_step(input logic r, input logic [1:0] sw);
    logic [1:0] no, nh;
    bit s, all_diff;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        xq[c] = '{1'b0, 1'b0};
        sh[c].delete();
        st[c] = 1'b0;
        age[c] = 0;
      end
      {m_out, m_rise, m_fall, m_held, m_hp} = '0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      xq[c].push_back(sw[c] ^ AL[c]);
      s = xq[c].pop_front();
      sh[c].push_back(s);
      if (sh[c].size() > DL + 1) void'(sh[c].pop_front());
      no[c] = st[c];
      all_diff = (sh[c].size() == DL + 1);
      foreach (sh[c][k]) if (sh[c][k] == st[c]) all_diff = 1'b0;
      if (all_diff) st[c] = !st[c];
      age[c] = m_out[c] ? age[c] + 1 : 0;
      nh[c] = age[c] >= HL;
    end
    m_rise = no & ~m_out;
    m_fall = ~no & m_out;
    m_hp = nh & ~m_held;
    m_out = no;
    m_held = nh;
  endfunction

  task automatic tick(input logic r, input logic [1:0] sw);
    i_Reset = r;
    i_Switch = sw;
    @(posedge clk);
    model_step(r, sw);
    #1;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      rise_cnt[c] += int'(o_Rise[c]);
      fall_cnt[c] += int'(o_Fall[c]);
    end
    check("o_Switch", o_Switch, m_out);
    check("o_Rise", o_Rise, m_rise);
    check("o_Fall", o_Fall, m_fall);
    check("o_Held", o_Held, m_held);
    check("o_Held_Pulse", o_Held_Pulse, m_hp);
    check("rise_fall_excl", o_Rise & o_Fall, 0);
  endtask

  task automatic clr_cnt();
    rise_cnt = '{0, 0};
    fall_cnt = '{0, 0};
  endtask

  initial begin
    logic [1:0] lvl;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    repeat (3) tick(1'b1, 2'b10);
    check("reset_all", {o_Switch, o_Rise, o_Fall, o_Held, o_Held_Pulse}, 0);
    repeat (3) tick(1'b0, 2'b10);
    check("al_idle_sw1", o_Switch[1], 0);
    clr_cnt();
    tick(1'b0, 2'b11);
    repeat (6) tick(1'b0, 2'b11);
    check("press_e6_sw0", o_Switch[0], 0);
    tick(1'b0, 2'b11);
    check("press_e7_sw0", o_Switch[0], 1);
    check("press_e7_rise0", o_Rise[0], 1);
    repeat (9) tick(1'b0, 2'b11);
    check("press_e16_held0", o_Held[0], 0);
    tick(1'b0, 2'b11);
    check("press_e17_held0", o_Held[0], 1);
    check("press_e17_hp0", o_Held_Pulse[0], 1);
    check("press_rise_cnt", rise_cnt[0], 1);
    check("press_no_fall", fall_cnt[0], 0);
    repeat (12) tick(1'b0, 2'b10);
    clr_cnt();
    foreach (lvl[k]) lvl[k] = 1'b0;
    tick(1'b0, 2'b11);
    tick(1'b0, 2'b11);
    tick(1'b0, 2'b11);
    tick(1'b0, 2'b10);
    tick(1'b0, 2'b11);
    repeat (6) tick(1'b0, 2'b11);
    check("bounce_e6_sw0", o_Switch[0], 0);
    tick(1'b0, 2'b11);
    check("bounce_e7_rise0", o_Rise[0], 1);
    repeat (3) tick(1'b0, 2'b11);
    check("bounce_rise_cnt", rise_cnt[0], 1);
    repeat (20) tick(1'b0, 2'b10);
    clr_cnt();
    repeat (DL) tick(1'b0, 2'b11);
    repeat (15) tick(1'b0, 2'b10);
    check("glitch_no_rise", rise_cnt[0], 0);
    repeat (DL + 1) tick(1'b0, 2'b11);
    repeat (15) tick(1'b0, 2'b10);
    check("limit_plus1_rise", rise_cnt[0], 1);
    clr_cnt();
    tick(1'b0, 2'b00);
    repeat (6) tick(1'b0, 2'b00);
    check("al_e6_sw1", o_Switch[1], 0);
    tick(1'b0, 2'b00);
    check("al_e7_sw1", o_Switch[1], 1);
    check("al_e7_rise1", o_Rise[1], 1);
    repeat (12) tick(1'b0, 2'b00);
    check("al_held1", o_Held[1], 1);
    tick(1'b0, 2'b10);
    repeat (6) tick(1'b0, 2'b10);
    tick(1'b0, 2'b10);
    check("al_fall1", o_Fall[1], 1);
    check("al_held_at_fall", o_Held[1], 1);
    tick(1'b0, 2'b10);
    check("al_held_clr", o_Held[1], 0);
    tick(1'b0, 2'b11);
    repeat (20) tick(1'b0, 2'b11);
    check("rst_pre_held0", o_Held[0], 1);
    tick(1'b1, 2'b11);
    check("rst_mid_all", {o_Switch, o_Rise, o_Fall, o_Held, o_Held_Pulse}, 0);
    tick(1'b0, 2'b11);
    repeat (6) tick(1'b0, 2'b11);
    check("rst_e6_rise0", o_Rise[0], 0);
    tick(1'b0, 2'b11);
    check("rst_e7_rise0", o_Rise[0], 1);
    repeat (12) tick(1'b0, 2'b00);
    tick(1'b0, 2'b11);
    repeat (6) tick(1'b0, 2'b11);
    tick(1'b0, 2'b11);
    check("simul_rise", o_Rise, 2'b01);
    check("simul_fall", o_Fall, 2'b10);
    lvl = 2'b11;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < 2; c++) if ($urandom_range(11) == 0) lvl[c] = !lvl[c];
      tick($urandom_range(299) == 0, lvl);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-switch debouncer, used for the board's push-buttons and DIP switches.
- Each channel has:
  - a 2-flop input synchroniser;
  - an independent stability counter;
  - an optional input inversion;
  - single-cycle rise/fall event pulses;
  - a long-press detector.
- Sits between the raw pins and the control/UI logic, so downstream logic never samples raw switches.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- DEBOUNCE_LIMIT, 250_000, stability threshold in clocks (10 ms at 25 MHz); must be ≥ 1.
- HOLD_LIMIT, 25_000_000, clocks the debounced state must stay at 1 before a long-press is flagged (1 s at 25 MHz); must be ≥ 1.
- ACTIVE_LOW, 0, bit vector [NUM_CH-1:0]. Bit n = 1 inverts channel n before the synchroniser, so pressed reads as 1.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Switch  in  NUM_CH  raw asynchronous switch/button pins.
- o_Switch  out  NUM_CH  debounced level per channel.
- o_Rise  out  NUM_CH  one-cycle pulse when o_Switch[n] goes 0→1.
- o_Fall  out  NUM_CH  one-cycle pulse when o_Switch[n] goes 1→0.
- o_Held  out  NUM_CH  level: o_Switch[n] has been 1 for ≥ HOLD_LIMIT cycles.
- o_Held_Pulse  out  NUM_CH  one-cycle pulse on the 0→1 transition of o_Held[n].

Behaviour:
- One clock (i_Clk), one reset (i_Reset), synchronous, active-high.
- Reset: clears every register in the same edge:
  - synchroniser flops, stability counters, state, hold counters;
  - all outputs go to 0.
  - Reset mid-count discards progress.
  - A switch already pressed at reset release is debounced from scratch and produces a normal o_Rise.
- Input conditioning: x[n] = i_Switch[n] XOR ACTIVE_LOW[n], passed through 2 flops to give s[n].
- Stability counter per channel, width $clog2(DEBOUNCE_LIMIT+1); the three rules below are mutually exclusive and evaluated in order:
  - s == state and count < DEBOUNCE_LIMIT: count = 0.
  - s != state and count < DEBOUNCE_LIMIT: count += 1.
  - count == DEBOUNCE_LIMIT:
    - if s != state: state <= s, count <= 0;
    - else: count <= 0, no commit. A bounce back in the commit cycle must not commit.
  - The counter never exceeds DEBOUNCE_LIMIT and never wraps.
- Latency: with i_Switch steady at a new level from edge E0 (first edge that samples it), o_Switch changes on edge E0 + 2 + DEBOUNCE_LIMIT + 1.
  - A single-cycle glitch of the opposite level anywhere in the window restarts the count.
- Event pulses, registered:
  - o_Rise[n] is high for exactly the one cycle in which o_Switch[n] first reads 1.
  - o_Fall[n] is the same for the first cycle reading 0.
  - Never both high at once on one channel.
- Long-press, per channel, hold counter width $clog2(HOLD_LIMIT+1):
  - Cleared while o_Switch[n] == 0.
  - Increments while o_Switch[n] == 1 and count < HOLD_LIMIT.
  - Saturates at HOLD_LIMIT.
  - o_Held[n] = (hold count == HOLD_LIMIT), registered.
  - o_Held_Pulse[n] is high for the single cycle o_Held[n] first reads 1.
  - Falling o_Switch clears o_Held in the cycle after o_Fall.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.

Decomposition:
- Package debounce_pkg:
  - clog2-based width helper function;
  - default-limit constants DEBOUNCE_10MS_25MHZ = 250_000 and HOLD_1S_25MHZ = 25_000_000.
- Sub-module debounce_channel:
  - one channel: synchroniser, stability counter, edge detect, hold logic;
  - scalar ports, plus an INVERT parameter.
- debounce_bank is a generate loop of NUM_CH instances driving ACTIVE_LOW[n] into INVERT.

Test Plan:
All scenarios use NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, ACTIVE_LOW=2'b10.

1. Clean press: raise i_Switch[0] at edge E0 and hold it.
   - o_Switch[0]=1 at E0+7.
   - o_Rise[0] is a single pulse in that cycle.
   - o_Held[0] and o_Held_Pulse[0] go high 10 edges later.
   - o_Fall[0] stays 0 throughout.
2. Bounce: i_Switch[0] pattern 1,1,1,0,1,1,1,1,1,1.
   - Count restarts at the 0.
   - o_Switch[0] rises 7 edges after the last restart.
   - Exactly one o_Rise pulse.
3. Commit-cycle glitch: i_Switch[0] high long enough for count to reach 4, then low exactly in the commit cycle.
   - No commit, o_Switch[0] stays 0, no o_Rise.
4. Active-low channel:
   - i_Switch[1]=1 from reset: o_Switch[1] stays 0.
   - Drive it to 0: o_Switch[1]=1 after 7 edges, with o_Rise[1].
   - Release: o_Fall[1] pulses and o_Held[1] clears.
5. Reset mid-operation: assert i_Reset for one cycle while channel 0 is held and o_Held[0]=1.
   - All outputs are 0 on the next edge.
   - With i_Switch[0] still high, o_Rise[0] re-fires 7 edges after reset deasserts.
6. Simultaneous: press ch0 and release ch1 on the same edge.
   - o_Rise[0] and o_Fall[1] pulse in the same cycle; no cross-channel interaction.
